// File: rtl/bram_stream_reader_if.sv
// Command, BRAM read port and output stream of the BRAM stream reader, bundled.
// master = the reader itself, slave = the command source, BRAM and stream sink.
interface bram_stream_reader_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_BYTES  = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  mem_ena;
  logic [NUM_BYTES-1:0]  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  busy;
  logic                  done;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, mem_dout, out_ready,
    output cmd_ready, mem_ena, mem_we, mem_addr, out_valid, out_data, out_last, busy, done
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, mem_dout, out_ready,
    input  cmd_ready, mem_ena, mem_we, mem_addr, out_valid, out_data, out_last, busy, done
  );
endinterface

// File: rtl/bram_stream_reader.sv
// Reads cmd_len sequential BRAM words from cmd_addr and streams them out with full backpressure.
// Words appear 2 cycles after their read issue; a 2-entry skid FIFO plus credit check absorbs the BRAM latency.
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_BYTES  = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  bram_stream_reader_if.master  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  issue_q, issue_d;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d;
  logic                  done_q, done_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            cnt_q;

  logic       pop;
  logic       issue;
  logic [2:0] occ;
  logic [2:0] avail;

  // A same-cycle pop frees a slot, so out_ready feeds mem_ena combinationally.
  assign pop   = (cnt_q != 2'd0) && bus.out_ready;
  assign occ   = {1'b0, cnt_q} + {2'b0, inflight_q};
  assign avail = occ - {2'b0, pop};
  assign issue = (state_q == RUN) && (issue_q != '0) && (avail < 3'd2);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    issue_d  = issue_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = RUN;
            addr_d   = bus.cmd_addr;
            issue_d  = bus.cmd_len;
            remain_d = bus.cmd_len;
          end
        end
      end
      RUN: begin
        if (issue) begin
          addr_d  = addr_q + 1'b1;
          issue_d = issue_q - 1'b1;
          if (issue_q == LEN_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: ;
      default: state_d = IDLE;
    endcase
    if (pop) begin
      remain_d = remain_q - 1'b1;
      if (remain_q == LEN_WIDTH'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      issue_q    <= '0;
      remain_q   <= '0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      issue_q    <= issue_d;
      remain_q   <= remain_d;
      done_q     <= done_d;
      inflight_q <= issue;
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= bus.mem_dout;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.mem_ena   = issue;
  assign bus.mem_we    = '0;
  assign bus.mem_addr  = addr_q;
  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.out_data  = fifo_q[rd_ptr_q];
  assign bus.out_last  = (cnt_q != 2'd0) && (remain_q == LEN_WIDTH'(1));

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: command table plus back-to-back and mid-run reset sequences.
module tb_bram_stream_reader;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [63:0] mem [4096];

  bram_stream_reader_if #(.ADDR_WIDTH(12), .DATA_WIDTH(64), .NUM_BYTES(8), .LEN_WIDTH(13)) bus ();

  bram_stream_reader #(.ADDR_WIDTH(12), .DATA_WIDTH(64), .NUM_BYTES(8), .LEN_WIDTH(13)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  // Registered-read BRAM model, one cycle of latency.
  always @(posedge clock) begin
    if (bus.mem_ena) bus.mem_dout <= mem[bus.mem_addr];
  end

  typedef struct {
    logic [11:0] addr;
    logic [12:0] len;
    logic [15:0] pat;
    int          lat;
    logic [63:0] d0;
    logic [63:0] dl;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v, input string nm);
    int          cyc, got, issued, last_cyc, first_cyc;
    logic [11:0] exp_ia, wa;
    logic [63:0] held, first_d, last_d;
    logic        stalled, fin, exp_done, exp_busy;
    @(negedge clock);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = v.addr;
    bus.cmd_len   = v.len;
    bus.out_ready = v.pat[0];
    #1 chk({nm, "_cmd_ready"}, bus.cmd_ready, 1);
    cyc = 1; got = 0; issued = 0; last_cyc = -1; first_cyc = -1;
    exp_ia = v.addr; stalled = 0; fin = 0; held = '0; first_d = '0; last_d = '0;
    while (!fin && cyc < 5000) begin
      @(negedge clock);
      bus.cmd_valid = 1'b0;
      bus.out_ready = v.pat[cyc % 16];
      #1;
      if (bus.mem_ena) begin
        chk({nm, "_mem_addr"}, bus.mem_addr, exp_ia);
        exp_ia++;
        issued++;
      end
      if (stalled) begin
        chk({nm, "_hold_valid"}, bus.out_valid, 1);
        chk({nm, "_hold_data"}, bus.out_data, held);
      end
      exp_done = (v.len == 0) ? (cyc == 1) : (last_cyc >= 0 && cyc == last_cyc + 1);
      exp_busy = (v.len != 0) && !(last_cyc >= 0 && cyc > last_cyc);
      chk({nm, "_done"}, bus.done, exp_done);
      chk({nm, "_busy"}, bus.busy, exp_busy);
      chk({nm, "_cmd_ready_run"}, bus.cmd_ready, !exp_busy);
      if (bus.out_valid && bus.out_ready) begin
        wa = v.addr + got[11:0];
        got++;
        chk({nm, "_data"}, bus.out_data, {52'b0, wa} * 64'h0101);
        chk({nm, "_last"}, bus.out_last, got == int'(v.len));
        if (got == 1) begin first_d = bus.out_data; first_cyc = cyc; end
        last_d = bus.out_data;
        if (got == int'(v.len)) last_cyc = cyc;
      end
      chk({nm, "_outstanding"}, (issued - got) <= 2, 1);
      stalled = bus.out_valid && !bus.out_ready;
      held    = bus.out_data;
      if (exp_done) fin = 1;
      cyc++;
    end
    chk({nm, "_completed"}, fin, 1);
    chk({nm, "_words"}, got, v.len);
    chk({nm, "_reads"}, issued, v.len);
    chk({nm, "_mem_we"}, bus.mem_we, 0);
    if (v.len != 0) begin
      chk({nm, "_first_data"}, first_d, v.d0);
      chk({nm, "_last_data"}, last_d, v.dl);
      if (v.lat != 0) begin
        chk({nm, "_latency"}, first_cyc, v.lat);
        chk({nm, "_throughput"}, last_cyc, v.lat + int'(v.len) - 1);
      end
    end
  endtask

  initial begin
    logic [63:0] exp_bb [5];
    logic        exp_bl [5];
    logic [63:0] bb_d [$];
    logic        bb_l [$];
    int          nacc, acc2_cyc, done1_cyc, ndone, hs;
    vec_t        fresh;

    tbl[0] = '{addr: 12'h010, len: 13'd4,      pat: 16'hFFFF, lat: 3, d0: 64'h1010,   dl: 64'h1313};
    tbl[1] = '{addr: 12'hFFE, len: 13'd4,      pat: 16'hFFFF, lat: 3, d0: 64'h100DFE, dl: 64'h0101};
    tbl[2] = '{addr: 12'h020, len: 13'd8,      pat: 16'hB4D9, lat: 0, d0: 64'h2020,   dl: 64'h2727};
    tbl[3] = '{addr: 12'h005, len: 13'd0,      pat: 16'hFFFF, lat: 0, d0: 64'h0,      dl: 64'h0};
    tbl[4] = '{addr: 12'h100, len: 13'd1,      pat: 16'hFFFF, lat: 3, d0: 64'h10100,  dl: 64'h10100};
    tbl[5] = '{addr: 12'hFFF, len: 13'd3,      pat: 16'h5555, lat: 0, d0: 64'h100EFF, dl: 64'h0101};
    tbl[6] = '{addr: 12'h123, len: 13'h1000,   pat: 16'hFFFF, lat: 3, d0: 64'h12423,  dl: 64'h12322};

    for (int i = 0; i < 4096; i++) mem[i] = 64'(i) * 64'h0101;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b0;
    bus.mem_dout  = '0;

    #12;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_mem_ena", bus.mem_ena, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    @(negedge clock);
    reset = 1'b0;

    for (int t = 0; t < 7; t++) run_cmd(tbl[t], $sformatf("vec%0d", t));

    // Back-to-back: second command held valid until accepted in the first one's done cycle.
    exp_bb = '{64'h4040, 64'h4141, 64'h5050, 64'h5151, 64'h5252};
    exp_bl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    @(negedge clock);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 12'h040;
    bus.cmd_len   = 13'd2;
    bus.out_ready = 1'b1;
    #1 chk("b2b_first_ready", bus.cmd_ready, 1);
    nacc = 1; acc2_cyc = -1; done1_cyc = -1; ndone = 0;
    for (int cyc = 1; cyc < 25; cyc++) begin
      @(negedge clock);
      if (nacc == 1) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 12'h050;
        bus.cmd_len   = 13'd3;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      #1;
      if (bus.done) begin
        ndone++;
        if (done1_cyc < 0) done1_cyc = cyc;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        nacc++;
        acc2_cyc = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        bb_d.push_back(bus.out_data);
        bb_l.push_back(bus.out_last);
      end
    end
    chk("b2b_first_done_cycle", done1_cyc, 5);
    chk("b2b_accept_cycle", acc2_cyc, 5);
    chk("b2b_done_count", ndone, 2);
    chk("b2b_words", bb_d.size(), 5);
    if (bb_d.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("b2b_data%0d", i), bb_d[i], exp_bb[i]);
        chk($sformatf("b2b_last%0d", i), bb_l[i], exp_bl[i]);
      end
    end

    // Asynchronous reset in the middle of a 16-word command.
    @(negedge clock);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 12'h200;
    bus.cmd_len   = 13'd16;
    bus.out_ready = 1'b1;
    hs = 0;
    for (int cyc = 0; cyc < 50 && hs < 5; cyc++) begin
      @(negedge clock);
      bus.cmd_valid = 1'b0;
      #1;
      if (bus.out_valid && bus.out_ready) hs++;
    end
    chk("arst_handshakes", hs, 5);
    #2 reset = 1'b1;
    #1;
    chk("arst_mem_ena", bus.mem_ena, 0);
    chk("arst_mem_addr", bus.mem_addr, 0);
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_out_last", bus.out_last, 0);
    chk("arst_out_data", bus.out_data, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_cmd_ready", bus.cmd_ready, 1);
    chk("arst_done", bus.done, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clock);
      #1;
      chk("post_rst_done", bus.done, 0);
      chk("post_rst_out_valid", bus.out_valid, 0);
      chk("post_rst_cmd_ready", bus.cmd_ready, 1);
    end
    fresh = '{addr: 12'h300, len: 13'd1, pat: 16'hFFFF, lat: 3, d0: 64'h30300, dl: 64'h30300};
    run_cmd(fresh, "fresh");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
